// File: rtl/unpacked_serializer_pkg.sv
// unpacked_serializer_pkg: shared state type and default element count.
// Define UNPACKED_SERIALIZER_PARITY_EN to add the PARITY state.
package unpacked_serializer_pkg;
  localparam int DEFAULT_N_ELEM = 8;
`ifdef UNPACKED_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
endpackage

// File: rtl/unpacked_parity.sv
// unpacked_parity: XOR reduction of an unpacked bit array.
// Ports: i_data - N-element unpacked array; o_par - XOR of all elements.
module unpacked_parity #(
  parameter int N = 8
) (
  input  logic i_data [N],
  output logic o_par
);
  always_comb begin
    o_par = 1'b0;
    foreach (i_data[i]) o_par = o_par ^ i_data[i];
  end
endmodule

// File: rtl/unpacked_serializer.sv
// unpacked_serializer: captures an N_ELEM unpacked bit array and emits it one
// bit per valid/ready beat, element 0 first.
// Ports: i_clk/i_rst (sync, active-high); i_load/i_data capture request and
// array; o_valid/i_ready/o_data/o_last beat handshake; o_busy frame active;
// o_done one-cycle pulse after the final beat.
// Macro UNPACKED_SERIALIZER_PARITY_EN appends an even-parity beat per frame.
module unpacked_serializer
  import unpacked_serializer_pkg::*;
#(
  parameter int N_ELEM = DEFAULT_N_ELEM
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_data [N_ELEM],
  output logic o_busy,
  output logic o_valid,
  input  logic i_ready,
  output logic o_data,
  output logic o_last,
  output logic o_done
);
  localparam int IW = $clog2(N_ELEM);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_ELEM - 1);
  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_shadow [N_ELEM];
  logic          r_done;
  logic          w_fire;
  logic          w_last_elem;
  logic          w_shift;
  assign w_shift     = r_state == SHIFT;
  assign w_last_elem = r_idx == LAST_IDX;
  assign o_busy      = r_state != IDLE;
  assign o_valid     = o_busy;
  assign o_done      = r_done;
  assign w_fire      = o_valid & i_ready;
`ifdef UNPACKED_SERIALIZER_PARITY_EN
  logic w_par;
  unpacked_parity #(.N(N_ELEM)) u_par (.i_data(r_shadow), .o_par(w_par));
  assign o_data = (r_state == PARITY) ? w_par : w_shift & r_shadow[r_idx];
  assign o_last = r_state == PARITY;
`else
  assign o_data = w_shift & r_shadow[r_idx];
  assign o_last = w_shift & w_last_elem;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
      foreach (r_shadow[i]) r_shadow[i] <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (i_load) begin
          foreach (r_shadow[i]) r_shadow[i] <= i_data[i];
          r_idx   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: if (w_fire) begin
          if (w_last_elem) begin
`ifdef UNPACKED_SERIALIZER_PARITY_EN
            r_state <= PARITY;
`else
            r_state <= IDLE;
            r_done  <= 1'b1;
`endif
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
        PARITY: if (w_fire) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unpacked_serializer.sv
// tb_unpacked_serializer: randomized self-checking bench with a queue-based frame model.
module tb_unpacked_serializer;
  logic clk = 1'b0;
  logic rst, load, ready, busy, valid, dout, last, done;
  logic data8 [8];
  logic cur [8];
  logic load2, busy2, valid2, dout2, last2, done2;
  logic data2 [2];
  logic cur2 [2];
  logic exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unpacked_serializer #(.N_ELEM(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_data(data8), .o_busy(busy),
    .o_valid(valid), .i_ready(ready), .o_data(dout), .o_last(last), .o_done(done)
  );

  unpacked_serializer #(.N_ELEM(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_load(load2), .i_data(data2), .o_busy(busy2),
    .o_valid(valid2), .i_ready(1'b1), .o_data(dout2), .o_last(last2), .o_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected beat list: elements in index order, plus parity beat when enabled.
  task automatic build_expect(input int n);
    logic p;
    p = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      logic b;
      b = (n == 8) ? cur[i] : cur2[i];
      exp_q.push_back(b);
      p ^= b;
    end
`ifdef UNPACKED_SERIALIZER_PARITY_EN
    exp_q.push_back(p);
`endif
  endtask

  task automatic frame(input int stall_beat, input int stall_len, input int inj_beat,
                       input int rst_beat, input bit rand_ready);
    int k, cyc, stalled, n;
    check("idle_valid", valid, 0);
    check("idle_busy", busy, 0);
    build_expect(8);
    n = exp_q.size();
    data8 = cur;
    load = 1'b1;
    tick();
    load = 1'b0;
    foreach (data8[i]) data8[i] = $urandom_range(0, 1);
    k = 0; cyc = 0; stalled = 0;
    while (k < n && cyc < 300) begin
      if (k == rst_beat) begin
        rst = 1'b1; load = 1'b1;
        tick();
        rst = 1'b0; load = 1'b0;
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", dout, 0);
        check("rst_last", last, 0);
        check("rst_done", done, 0);
        return;
      end
      if (k == inj_beat) begin
        load = 1'b1;
        foreach (data8[i]) data8[i] = 1'b1;
      end else load = 1'b0;
      if (k == stall_beat && stalled < stall_len) begin
        ready = 1'b0;
        stalled++;
      end else ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      check("valid", valid, 1);
      check("busy", busy, 1);
      check($sformatf("data_b%0d", k), dout, exp_q[k]);
      check($sformatf("last_b%0d", k), last, k == n - 1);
      check("done_mid", done, 0);
      tick();
      if (ready) k++;
      cyc++;
    end
    load = 1'b0;
    if (cyc >= 300) check("timeout", 0, 1);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", valid, 0);
    tick();
    check("done_once", done, 0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; ready = 1'b0; load2 = 1'b0;
    foreach (data8[i]) data8[i] = 1'b1;
    foreach (data2[i]) data2[i] = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    check("rst_valid0", valid, 0);
    check("rst_busy0", busy, 0);
    check("rst_data0", dout, 0);
    check("rst_last0", last, 0);
    check("rst_done0", done, 0);
    cur = '{1, 0, 1, 1, 0, 0, 1, 0};
    frame(-1, 0, -1, -1, 0);
    frame(2, 3, -1, -1, 0);
    frame(-1, 0, 3, -1, 0);
    frame(-1, 0, -1, 4, 0);
    frame(-1, 0, -1, -1, 0);
    cur = '{1, 1, 1, 1, 1, 1, 1, 1};
    frame(-1, 0, -1, -1, 1);
    cur = '{0, 0, 0, 0, 0, 0, 0, 1};
    frame(-1, 0, -1, -1, 1);
    for (int f = 0; f < 20; f++) begin
      foreach (cur[i]) cur[i] = $urandom_range(0, 1);
      frame(-1, 0, $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : -1, -1, 1);
    end
    // N_ELEM=2 with load held: one idle (done) cycle between frames.
    ready = 1'b0;
    foreach (cur2[i]) cur2[i] = $urandom_range(0, 1);
    data2 = cur2;
    load2 = 1'b1;
    tick();
    for (int f = 0; f < 6; f++) begin
      build_expect(2);
      for (int b = 0; b < exp_q.size(); b++) begin
        check("n2_valid", valid2, 1);
        check("n2_data", dout2, exp_q[b]);
        check("n2_last", last2, b == exp_q.size() - 1);
        check("n2_done", done2, 0);
        if (b == 0) foreach (data2[i]) data2[i] = $urandom_range(0, 1);
        if (b == exp_q.size() - 1) begin
          foreach (cur2[i]) cur2[i] = $urandom_range(0, 1);
          data2 = cur2;
        end
        tick();
      end
      check("n2_done_pulse", done2, 1);
      check("n2_gap_valid", valid2, 0);
      check("n2_gap_busy", busy2, 0);
      tick();
    end
    load2 = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/unpacked_serializer.md
UNPACKED_SERIALIZER -- requirements
Module: unpacked_serializer

Interface
REQ-001 SHALL have parameter N_ELEM, default 8, number of unpacked array elements captured per load; legal range 2..256.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port i_load  input  1  request to capture i_data.
REQ-005 SHALL have port i_data  input  unpacked logic [N_ELEM]  parallel element array, C-style declaration.
REQ-006 SHALL have port o_busy  output  1  high while a captured array is being emitted.
REQ-007 SHALL have port o_valid  output  1  output beat valid.
REQ-008 SHALL have port i_ready  input  1  downstream accepts beat.
REQ-009 SHALL have port o_data  output  1  current beat value.
REQ-010 SHALL have port o_last  output  1  marks final beat of a frame.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse after the final beat is accepted.

Function
REQ-012 SHALL implement states IDLE, SHIFT, and PARITY; PARITY exists only when the parity feature is enabled.
REQ-013 In IDLE with i_load=1, the block SHALL copy all N_ELEM elements of i_data into an internal unpacked shadow array (foreach), clear the index to 0, and enter SHIFT on the next edge.
REQ-014 Load-to-first-valid latency SHALL be exactly 1 cycle.
REQ-015 In SHIFT: o_valid=1, o_data=shadow[idx], and elements are emitted in ascending index order (0 first).
REQ-016 A beat SHALL transfer only on a cycle with o_valid=1 and i_ready=1; idx increments by 1 per transfer.
REQ-017 o_data and o_last SHALL hold stable while o_valid=1 and i_ready=0.
REQ-018 idx width SHALL be $clog2(N_ELEM); idx never exceeds N_ELEM-1 and does not wrap.
REQ-019 On transfer at idx=N_ELEM-1, the block SHALL go to PARITY if enabled, else to IDLE.
REQ-020 o_last SHALL be high only on the final beat of the frame.
REQ-021 o_done SHALL pulse for exactly one cycle, the cycle after the final transfer, coincident with return to IDLE.
REQ-022 i_load while o_busy=1 SHALL be ignored; the shadow array SHALL not change mid-frame.
REQ-023 i_load in the same cycle as o_done (state IDLE) SHALL be accepted, giving back-to-back frames with one idle cycle.
REQ-024 o_busy SHALL equal (state != IDLE).
REQ-025 The block SHALL not require i_ready to be high before o_valid rises.

Reset
REQ-026 With i_rst=1 at a clock edge: state=IDLE, idx=0, shadow all 0, and o_valid, o_data, o_last, o_done, o_busy all 0 from the following cycle.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no o_done pulse; a load on the first cycle after reset deasserts SHALL be accepted.
REQ-028 i_rst SHALL take priority over i_load.

Configuration
REQ-029 Macro UNPACKED_SERIALIZER_PARITY_EN, when defined, SHALL add the PARITY state, which emits one extra beat o_data = XOR of all captured elements (even parity) with o_last=1; the frame is then N_ELEM+1 beats.
REQ-030 Without UNPACKED_SERIALIZER_PARITY_EN, frames SHALL be N_ELEM beats, o_last SHALL be on element N_ELEM-1, and no parity logic SHALL be present.

Structure
REQ-031 Package unpacked_serializer_pkg SHALL hold the state enum type (state_t) and the DEFAULT_N_ELEM=8 constant.
REQ-032 The parity reduction SHALL be a sub-module unpacked_parity (input unpacked array, output 1-bit XOR), instantiated only under the macro.
REQ-033 The shadow array SHALL be an unpacked logic array written with non-blocking assignments in always_ff.

Verification
REQ-034 Reset, then i_data={1,0,1,1,0,0,1,0} (index 0..7), i_load=1, i_ready=1 -> o_valid rises 1 cycle later; o_data sequence 1,0,1,1,0,0,1,0; o_last on beat 8; o_done 1 cycle later.
REQ-035 Same frame with i_ready=0 for 3 cycles at beat 3 -> o_data holds 1 and idx holds for those 3 cycles; the sequence is otherwise unchanged.
REQ-036 i_load pulsed with i_data all-ones at beat 4 of an active frame -> remaining beats still come from the original array.
REQ-037 i_rst=1 at beat 5 -> all outputs 0 the next cycle, no o_done; a new load then completes normally.
REQ-038 With UNPACKED_SERIALIZER_PARITY_EN and the data from REQ-034 -> 9 beats; beat 9 is o_data=0 (four ones) with o_last=1; all-ones data -> parity beat 0; single one at index 7 -> parity beat 1.
REQ-039 N_ELEM=2, i_load held high continuously -> frames repeat with exactly one IDLE cycle between each o_done and the next o_valid.
